// File: rtl/nor_rs_pkg.sv
// Shared constants and request decoding for the nor_rs storage bank.
// Policy selectors, reset values and the sampled {s,r} request encoding.
package nor_rs_pkg;

    localparam int POLICY_NOR  = 0;
    localparam int POLICY_HOLD = 1;

    localparam logic Q_RST  = 1'b0;
    localparam logic QB_RST = 1'b1;

    // Encoding is {s, r} so the enum value reads straight off the truth table.
    typedef enum logic [1:0] {
        REQ_HOLD  = 2'b00,
        REQ_RESET = 2'b01,
        REQ_SET   = 2'b10,
        REQ_BOTH  = 2'b11
    } req_e;

    function automatic req_e decode_req(input logic s, input logic r);
        return req_e'({s, r});
    endfunction

endpackage

// File: rtl/nor_rs_sync.sv
// Two-flop per-bit synchronizer for asynchronous r/s requests.
// Used by nor_rs only when NOR_RS_SYNC_EN is defined.
module nor_rs_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: sequential state uses non-blocking assignments so both flops
    // sample their inputs from before the edge; blocking here would collapse
    // the two stages into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nor_rs.sv
// Clocked bank of WIDTH set/reset bits with cross-coupled-NOR truth table.
// Optional input synchronizers under `ifdef NOR_RS_SYNC_EN (latency 3, else 1).
module nor_rs
    import nor_rs_pkg::*;
#(
    parameter int WIDTH          = 1,
    parameter int ILLEGAL_POLICY = POLICY_NOR
) (
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] s,
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] illegal
);

    logic [WIDTH-1:0] r_req;
    logic [WIDTH-1:0] s_req;

`ifdef NOR_RS_SYNC_EN
    nor_rs_sync #(.WIDTH(WIDTH)) u_sync_r (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (r),
        .q     (r_req)
    );

    nor_rs_sync #(.WIDTH(WIDTH)) u_sync_s (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (s),
        .q     (s_req)
    );
`else
    assign r_req = r;
    assign s_req = s;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic q_reg, qb_reg, ill_reg;
        logic q_next, qb_next;

        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred for the combinational next-state logic.
        always_comb begin
            q_next  = q_reg;
            qb_next = ~q_reg;
            unique case (decode_req(s_req[i], r_req[i]))
                REQ_HOLD: begin
                    // qb re-derives from q, so leaving 1/1 under the NOR
                    // policy lands on q=0 qb=1 with no oscillation.
                    q_next  = q_reg;
                    qb_next = ~q_reg;
                end
                REQ_SET: begin
                    q_next  = 1'b1;
                    qb_next = 1'b0;
                end
                REQ_RESET: begin
                    q_next  = 1'b0;
                    qb_next = 1'b1;
                end
                REQ_BOTH: begin
                    if (ILLEGAL_POLICY == POLICY_HOLD) begin
                        q_next  = q_reg;
                        qb_next = ~q_reg;
                    end else begin
                        q_next  = 1'b0;
                        qb_next = 1'b0;
                    end
                end
                default: begin
                    q_next  = q_reg;
                    qb_next = ~q_reg;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_reg   <= Q_RST;
                qb_reg  <= QB_RST;
                ill_reg <= 1'b0;
            end else begin
                q_reg   <= q_next;
                qb_reg  <= qb_next;
                ill_reg <= s_req[i] & r_req[i];
            end
        end

        assign q[i]       = q_reg;
        assign qb[i]      = qb_reg;
        assign illegal[i] = ill_reg;
    end

endmodule

// File: tb/tb_nor_rs.sv
// Self-checking bench for nor_rs: a 4-bit NOR-policy bank and a 1-bit hold-policy bit.
// Expected outputs are pushed when stimulus is driven and popped after the pipeline latency.
module tb_nor_rs;

`ifdef NOR_RS_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] s0 = '0, r0 = '0;
    logic [0:0] s1 = '0, r1 = '0;
    logic [3:0] q0, qb0, ill0;
    logic [0:0] q1, qb1, ill1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] q0, qb0, ill0;
        logic       q1, qb1, ill1;
    } exp_t;

    exp_t sb[$];

    // Reference state of both banks
    logic [3:0] m0_q, m0_ill;
    logic       m1_q, m1_ill;

    nor_rs #(.WIDTH(4), .ILLEGAL_POLICY(0)) dut0 (
        .q       (q0),
        .qb      (qb0),
        .r       (r0),
        .s       (s0),
        .clk     (clk),
        .rst_n   (rst_n),
        .illegal (ill0)
    );

    nor_rs #(.WIDTH(1), .ILLEGAL_POLICY(1)) dut1 (
        .q       (q1),
        .qb      (qb1),
        .r       (r1),
        .s       (s1),
        .clk     (clk),
        .rst_n   (rst_n),
        .illegal (ill1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m0_q = '0; m0_ill = '0;
        m1_q = 1'b0; m1_ill = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle of requests, predict the result, compare once the pipeline delivers it.
    task automatic step(input logic [3:0] sv0, input logic [3:0] rv0,
                        input logic sv1, input logic rv1, input string tag);
        exp_t e;
        @(negedge clk);
        s0 = sv0; r0 = rv0; s1 = sv1; r1 = rv1;
        m0_q   = (m0_q & ~sv0 & ~rv0) | (sv0 & ~rv0);
        m0_ill = sv0 & rv0;
        m1_q   = (m1_q & ~(sv1 ^ rv1)) | (sv1 & ~rv1);
        m1_ill = sv1 & rv1;
        e.tag  = tag;
        e.q0   = m0_q;  e.qb0 = ~m0_q & ~m0_ill; e.ill0 = m0_ill;
        e.q1   = m1_q;  e.qb1 = ~m1_q;           e.ill1 = m1_ill;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == LAT) begin
            e = sb.pop_front();
            check({e.tag, ".q0"},   q0,   e.q0);
            check({e.tag, ".qb0"},  qb0,  e.qb0);
            check({e.tag, ".ill0"}, ill0, e.ill0);
            check({e.tag, ".q1"},   {3'b0, q1},   {3'b0, e.q1});
            check({e.tag, ".qb1"},  {3'b0, qb1},  {3'b0, e.qb1});
            check({e.tag, ".ill1"}, {3'b0, ill1}, {3'b0, e.ill1});
        end
    endtask

    // Assert reset between edges with s held high; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        @(negedge clk);
        s0 = 4'hF; r0 = '0; s1 = 1'b1; r1 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, ".q0"},   q0,   4'h0);
        check({tag, ".qb0"},  qb0,  4'hF);
        check({tag, ".ill0"}, ill0, 4'h0);
        check({tag, ".q1"},   {3'b0, q1},   4'h0);
        check({tag, ".qb1"},  {3'b0, qb1},  4'h1);
        check({tag, ".ill1"}, {3'b0, ill1}, 4'h0);
        @(negedge clk);
        s0 = '0; s1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset("rst_init");

        // Latency: one-cycle s pulse on bit 0, q rises on edge LAT
        @(negedge clk);
        s0 = 4'h1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("lat_edge%0d", e), {3'b0, q0[0]}, {3'b0, (e >= LAT)});
            @(negedge clk);
            s0 = '0;
        end

        do_reset("rst_after_lat");

        step(4'h0, 4'hF, 1'b1, 1'b0, "reset_req");
        step(4'h0, 4'h0, 1'b0, 1'b0, "reset_hold");
        step(4'hF, 4'h0, 1'b1, 1'b1, "set_req");
        for (int i = 0; i < 10; i++)
            step(4'h0, 4'h0, 1'b0, 1'b0, $sformatf("set_hold%0d", i));
        step(4'hF, 4'hF, 1'b0, 1'b1, "both_nor");
        step(4'h0, 4'h0, 1'b1, 1'b1, "leave_both");
        step(4'h5, 4'hA, 1'b0, 1'b0, "w4_pattern");
        step(4'h3, 4'h3, 1'b1, 1'b0, "mixed_both");
        step(4'h0, 4'h0, 1'b1, 1'b1, "mixed_leave");
        step(4'h0, 4'h0, 1'b0, 1'b0, "drain0");
        step(4'h0, 4'h0, 1'b0, 1'b0, "drain1");

        do_reset("rst_midop");
        step(4'h0, 4'h0, 1'b0, 1'b0, "post_rst0");
        step(4'h0, 4'h0, 1'b0, 1'b0, "post_rst1");
        step(4'h0, 4'h0, 1'b0, 1'b0, "post_rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
